// File: rtl/pam_result_fifo_pkg.sv
// Shared sizing for the adding-machine result path and the capture-filter helper.
package pam_result_fifo_pkg;

   localparam int PAM_WIDTH      = 32;
   localparam int PAM_FIFO_DEPTH = 8;

   // Without the filter every valid cycle is a push. With it, only a value that differs from
   // the last captured one is a push, or any value when nothing has been captured yet.
   function automatic logic push_wanted(
      input logic change_only,
      input logic valid,
      input logic last_vld,
      input logic differs
   );
      return valid && (!change_only || !last_vld || differs);
   endfunction

endpackage

// File: rtl/pam_fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module pam_fifo_mem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/pam_result_fifo.sv
// Captures the adding machine's running sum into a first-word-fall-through FIFO,
// optionally skipping repeats, and counts pushes lost while full.
module pam_result_fifo
   import pam_result_fifo_pkg::*;
#(
   parameter int WIDTH       = PAM_WIDTH,
   parameter int DEPTH       = PAM_FIFO_DEPTH,
   parameter bit CHANGE_ONLY = 1'b1,
   parameter int DROP_W      = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   overflow,
   output logic [DROP_W-1:0]      drop_count
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic [WIDTH-1:0]  r_last;
   logic              r_last_vld;
   logic              r_overflow;
   logic [DROP_W-1:0] r_drop_count;

   logic              w_push_req;
   logic              w_push;
   logic              w_pop;
   logic              w_drop;
   logic              w_full;
   logic              w_empty;
   logic [WIDTH-1:0]  w_rdata;

   assign w_full     = (r_count == FULL_CNT);
   assign w_empty    = (r_count == '0);
   assign w_push_req = push_wanted(CHANGE_ONLY, in_valid, r_last_vld, in_data != r_last);
   assign w_pop      = !w_empty && out_ready;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;

   pam_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (w_push),
      .waddr (r_wr_ptr),
      .wdata (in_data),
      .raddr (r_rd_ptr),
      .rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_last       <= '0;
         r_last_vld   <= 1'b0;
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         // The filter tracks what was offered, so a dropped value still suppresses its repeats.
         if (w_push_req) begin
            r_last     <= in_data;
            r_last_vld <= 1'b1;
         end
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) r_drop_count <= r_drop_count + DROP_W'(1);
         end
      end
   end

   assign count      = r_count;
   assign full       = w_full;
   assign out_valid  = !w_empty;
   assign out_data   = w_empty ? '0 : w_rdata;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;

endmodule

// File: tb/tb_pam_result_fifo.sv
// Directed bench for pam_result_fifo: a filtering instance and an unfiltered instance share stimulus.
module tb_pam_result_fifo;

   localparam int W = 32;
   localparam int D = 8;

   logic        clk;
   logic        reset;
   logic [W-1:0] in_data;
   logic        in_valid;
   logic        out_ready;

   logic [W-1:0] o_data  [2];
   logic         o_valid [2];
   logic [3:0]   o_count [2];
   logic         o_full  [2];
   logic         o_ovf   [2];
   logic [7:0]   o_drop  [2];

   int errors = 0;
   int checks = 0;

   // Instance 0 filters repeats, instance 1 captures every valid cycle.
   pam_result_fifo #(.WIDTH(W), .DEPTH(D), .CHANGE_ONLY(1'b1), .DROP_W(8)) u_dut_co (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .out_data(o_data[0]), .out_valid(o_valid[0]), .out_ready(out_ready),
      .count(o_count[0]), .full(o_full[0]), .overflow(o_ovf[0]), .drop_count(o_drop[0]));

   pam_result_fifo #(.WIDTH(W), .DEPTH(D), .CHANGE_ONLY(1'b0), .DROP_W(8)) u_dut_all (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .out_data(o_data[1]), .out_valid(o_valid[1]), .out_ready(out_ready),
      .count(o_count[1]), .full(o_full[1]), .overflow(o_ovf[1]), .drop_count(o_drop[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: each instance is an ordered list whose element 0 is the head.
   logic [W-1:0] m_buf  [2][D];
   int           m_n    [2];
   logic [W-1:0] m_last [2];
   bit           m_lv   [2];
   bit           m_ovf  [2];
   int           m_drop [2];
   bit           model_ok = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!reset) begin
               m_n[k] = 0; m_last[k] = '0; m_lv[k] = 1'b0; m_ovf[k] = 1'b0; m_drop[k] = 0;
            end else begin
               int  n;
               bit  pop;
               bit  want;
               n    = m_n[k];
               pop  = (n > 0) && out_ready;
               want = in_valid && ((k == 1) || !m_lv[k] || (in_data != m_last[k]));
               if (want) begin
                  m_last[k] = in_data;
                  m_lv[k]   = 1'b1;
               end
               if (pop) begin
                  for (int j = 0; j < D - 1; j++) m_buf[k][j] = m_buf[k][j+1];
                  m_n[k] = m_n[k] - 1;
               end
               if (want) begin
                  if (n < D || pop) begin
                     m_buf[k][m_n[k]] = in_data;
                     m_n[k] = m_n[k] + 1;
                  end else begin
                     m_ovf[k] = 1'b1;
                     if (m_drop[k] < 255) m_drop[k] = m_drop[k] + 1;
                  end
               end
            end
         end
         if (!reset) model_ok = 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (model_ok) begin
            for (int k = 0; k < 2; k++) begin
               chk($sformatf("m%0d.count", k), 64'(o_count[k]), 64'(m_n[k]));
               chk($sformatf("m%0d.valid", k), 64'(o_valid[k]), 64'(m_n[k] > 0));
               chk($sformatf("m%0d.full", k),  64'(o_full[k]),  64'(m_n[k] == D));
               chk($sformatf("m%0d.data", k),  64'(o_data[k]),  (m_n[k] > 0) ? 64'(m_buf[k][0]) : 64'd0);
               chk($sformatf("m%0d.ovf", k),   64'(o_ovf[k]),   64'(m_ovf[k]));
               chk($sformatf("m%0d.drop", k),  64'(o_drop[k]),  64'(m_drop[k]));
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   logic [W-1:0] got[$];
   logic [W-1:0] seq2[6];

   initial begin
      int pushed;
      int c;
      reset = 1'b0; in_valid = 1'b1; in_data = 32'd5; out_ready = 1'b0;

      // Reset held with live input.
      repeat (6) begin
         tick();
         chk("rst.count", 64'(o_count[0]), 64'd0);
         chk("rst.valid", 64'(o_valid[1]), 64'd0);
         chk("rst.data",  64'(o_data[1]),  64'd0);
         chk("rst.ovf",   64'(o_ovf[1]),   64'd0);
      end
      reset = 1'b1; in_valid = 1'b0;
      tick();

      // Change filter.
      seq2[0] = 1; seq2[1] = 1; seq2[2] = 3; seq2[3] = 3; seq2[4] = 3; seq2[5] = 6;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = seq2[i];
         tick();
      end
      in_valid = 1'b0;
      chk("filt.count_co",  64'(o_count[0]), 64'd3);
      chk("filt.count_all", 64'(o_count[1]), 64'd6);
      out_ready = 1'b1;
      chk("filt.head1", 64'(o_data[0]), 64'd1); tick();
      chk("filt.head3", 64'(o_data[0]), 64'd3); tick();
      chk("filt.head6", 64'(o_data[0]), 64'd6); tick();
      chk("filt.empty", 64'(o_valid[0]), 64'd0);
      out_ready = 1'b0;

      reset = 1'b0; tick(); reset = 1'b1;

      // Fill past full.
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 32'h10 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      chk("fill.full",  64'(o_full[1]),  64'd1);
      chk("fill.count", 64'(o_count[1]), 64'd8);
      chk("fill.ovf",   64'(o_ovf[1]),   64'd1);
      chk("fill.drop",  64'(o_drop[1]),  64'd2);

      // Push while full, popping the same cycle.
      in_valid = 1'b1; in_data = 32'hAA; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("fullpp.count", 64'(o_count[1]), 64'd8);
      chk("fullpp.drop",  64'(o_drop[1]),  64'd2);
      for (int i = 1; i < 8; i++) begin
         chk("fullpp.order", 64'(o_data[1]), 64'h10 + 64'(i));
         tick();
      end
      chk("fullpp.aa", 64'(o_data[1]), 64'hAA);
      tick();
      chk("fullpp.empty", 64'(o_valid[1]), 64'd0);

      // Wrap-around with a toggling consumer.
      got.delete();
      pushed = 0; c = 0;
      while (pushed < 20 && c < 100) begin
         in_valid = (c % 3 != 2);
         if (in_valid) begin
            in_data = 32'h100 + 32'(pushed);
            pushed++;
         end
         out_ready = c[0];
         if (o_valid[1] && out_ready) got.push_back(o_data[1]);
         tick();
         c++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 40 && o_valid[1]; i++) begin
         got.push_back(o_data[1]);
         tick();
      end
      chk("wrap.size", 64'(got.size()), 64'd20);
      for (int i = 0; i < got.size() && i < 20; i++)
         chk("wrap.order", 64'(got[i]), 64'h100 + 64'(i));

      // Reset mid-stream; the filter history must be forgotten.
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 32'h7; tick();
      in_data = 32'h5; tick();
      in_data = 32'h1; tick();
      in_data = 32'h2; tick();
      in_data = 32'h3; tick();
      in_valid = 1'b0;
      chk("mrst.count5", 64'(o_count[0]), 64'd5);
      reset = 1'b0; out_ready = 1'b1;
      tick();
      reset = 1'b1; out_ready = 1'b0;
      chk("mrst.count0", 64'(o_count[0]), 64'd0);
      chk("mrst.valid0", 64'(o_valid[0]), 64'd0);
      in_valid = 1'b1; in_data = 32'h3;
      tick();
      in_valid = 1'b0;
      chk("mrst.repush", 64'(o_count[0]), 64'd1);
      chk("mrst.data",   64'(o_data[0]),  64'h3);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
